// File: rtl/duty_meas_pkg.sv
// Shared types and default sizing for the time-shared PWM duty/period monitor.
// Optional input synchronizer is selected with the DMS_SYNC_EN macro (see duty_meas_sched).
package duty_meas_pkg;

    localparam int DMS_NCH     = 4;
    localparam int DMS_CW      = 8;
    localparam int DMS_TMO_CYC = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_ARM,
        ST_HIGH,
        ST_LOW,
        ST_DONE
    } dms_state_t;

endpackage

// File: rtl/duty_meas_if.sv
// Bundle of PWM inputs, enable mask and the result port of the duty/period monitor.
// Result handshake: a result transfers on a cycle where res_vld & res_rdy; while res_vld is
// high and res_rdy low, every res_* field holds steady, and res_vld never drops without a transfer.
interface duty_meas_if #(
    parameter int NCH = 4,
    parameter int CW  = 8
);
    localparam int CHW = $clog2(NCH);

    logic [NCH-1:0] pwm;
    logic [NCH-1:0] ch_en;
    logic           res_vld;
    logic           res_rdy;
    logic [CHW-1:0] res_ch;
    logic [CW-1:0]  res_duty;
    logic [CW-1:0]  res_period;
    logic           res_tmo;

    modport master (
        input  pwm, ch_en, res_rdy,
        output res_vld, res_ch, res_duty, res_period, res_tmo
    );

    modport slave (
        output pwm, ch_en, res_rdy,
        input  res_vld, res_ch, res_duty, res_period, res_tmo
    );

endinterface

// File: rtl/duty_meas_core.sv
// Edge detector and saturating duty/period counters for the currently selected PWM bit.
// The scheduler's state decides when counters clear, start and advance.
module duty_meas_core
    import duty_meas_pkg::*;
#(
    parameter int CW = DMS_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwm_i,
    input  dms_state_t    state_i,
    output logic          rise_o,
    output logic          load_o,
    output logic [CW-1:0] duty_o,
    output logic [CW-1:0] period_o
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          prev_q;
    logic [CW-1:0] duty_q, duty_d;
    logic [CW-1:0] per_q, per_d;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign rise_o   = pwm_i & ~prev_q;
    // The second rising edge closes the period; counts at that moment are the result.
    assign load_o   = (state_i == ST_LOW) & rise_o;
    assign duty_o   = duty_q;
    assign period_o = per_q;

    always_comb begin
        duty_d = duty_q;
        per_d  = per_q;
        case (state_i)
            ST_SEL: begin
                duty_d = '0;
                per_d  = '0;
            end
            ST_ARM: begin
                if (rise_o) begin
                    duty_d = CW'(1);
                    per_d  = CW'(1);
                end
            end
            ST_HIGH: begin
                per_d = sat_inc(per_q);
                if (pwm_i) begin
                    duty_d = sat_inc(duty_q);
                end
            end
            ST_LOW: begin
                per_d = sat_inc(per_q);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
            duty_q <= '0;
            per_q  <= '0;
        end else begin
            prev_q <= pwm_i;
            duty_q <= duty_d;
            per_q  <= per_d;
        end
    end

endmodule

// File: rtl/duty_meas_sched.sv
// Round-robin scheduler sharing one duty/period datapath across NCH PWM inputs.
// Define DMS_SYNC_EN to put a 2-flop synchronizer on every pwm bit ahead of the channel mux.
module duty_meas_sched
    import duty_meas_pkg::*;
#(
    parameter int NCH     = DMS_NCH,
    parameter int CW      = DMS_CW,
    parameter int TMO_CYC = DMS_TMO_CYC
) (
    input  logic        clk,
    input  logic        rst,
    duty_meas_if.master bus_io,
    output dms_state_t  dbg_state_o
);

    localparam int CHW = $clog2(NCH);
    localparam int TW  = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    logic [NCH-1:0] pwm_s;

`ifdef DMS_SYNC_EN
    logic [NCH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus_io.pwm;
            sync2_q <= sync1_q;
        end
    end

    assign pwm_s = sync2_q;
`else
    assign pwm_s = bus_io.pwm;
`endif

    dms_state_t     state_q;
    logic [CHW-1:0] ptr_q, sel_q;
    logic [TW-1:0]  tmo_q;
    logic           res_vld_q, res_tmo_q;
    logic [CHW-1:0] res_ch_q;
    logic [CW-1:0]  res_duty_q, res_period_q;

    logic           pwm_bit, rise, load;
    logic [CW-1:0]  duty_cnt, per_cnt;
    logic [CHW-1:0] base, idx, pick;
    logic           any_en;

    assign pwm_bit = pwm_s[sel_q];

    // On acceptance the pointer becomes sel, so the search starts after sel right away.
    always_comb begin
        base   = (state_q == ST_DONE) ? sel_q : ptr_q;
        any_en = |bus_io.ch_en;
        pick   = base;
        idx    = base;
        for (int k = NCH; k >= 1; k--) begin
            idx = CHW'((int'(base) + k) % NCH);
            if (bus_io.ch_en[idx]) begin
                pick = idx;
            end
        end
    end

    duty_meas_core #(.CW(CW)) u_core (
        .clk      (clk),
        .rst      (rst),
        .pwm_i    (pwm_bit),
        .state_i  (state_q),
        .rise_o   (rise),
        .load_o   (load),
        .duty_o   (duty_cnt),
        .period_o (per_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= CHW'(NCH - 1);
            sel_q        <= '0;
            tmo_q        <= '0;
            res_vld_q    <= 1'b0;
            res_ch_q     <= '0;
            res_duty_q   <= '0;
            res_period_q <= '0;
            res_tmo_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_en) begin
                        sel_q   <= pick;
                        state_q <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    tmo_q   <= '0;
                    state_q <= ST_ARM;
                end
                ST_ARM, ST_HIGH, ST_LOW: begin
                    tmo_q <= tmo_q + 1'b1;
                    // A period that closes on the last allowed cycle wins over the timeout.
                    if (load) begin
                        res_vld_q    <= 1'b1;
                        res_ch_q     <= sel_q;
                        res_duty_q   <= duty_cnt;
                        res_period_q <= per_cnt;
                        res_tmo_q    <= 1'b0;
                        state_q      <= ST_DONE;
                    end else if (tmo_q == TMO_LAST) begin
                        res_vld_q    <= 1'b1;
                        res_ch_q     <= sel_q;
                        res_duty_q   <= '0;
                        res_period_q <= '0;
                        res_tmo_q    <= 1'b1;
                        state_q      <= ST_DONE;
                    end else if (state_q == ST_ARM && rise) begin
                        state_q <= ST_HIGH;
                    end else if (state_q == ST_HIGH && !pwm_bit) begin
                        state_q <= ST_LOW;
                    end
                end
                ST_DONE: begin
                    if (bus_io.res_rdy) begin
                        res_vld_q <= 1'b0;
                        ptr_q     <= sel_q;
                        if (any_en) begin
                            sel_q   <= pick;
                            state_q <= ST_SEL;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_io.res_vld    = res_vld_q;
    assign bus_io.res_ch     = res_ch_q;
    assign bus_io.res_duty   = res_duty_q;
    assign bus_io.res_period = res_period_q;
    assign bus_io.res_tmo    = res_tmo_q;
    assign dbg_state_o       = state_q;

endmodule
